y86_mem_arbiter: RTL
====================

Name: y86_mem_arbiter

Overview:
- Shares one single-port unified memory between two Y86 pipeline clients: the fetch stage (read only) and the memory stage (read/write).
- Sequences each access with a req/ack handshake on the memory side.
- Drives stall requests that the pipeline control logic folds into F_stall / M_bubble.
- Reports access timeouts as errors so the memory stage can raise SADR.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width for both clients and the memory port.
- TIMEOUT, 15, max cycles in an access state without mem_ack before abort; must be ≥1.
- STARVE_LIM, 4, consecutive memory-stage grants won while f_req is pending before fetch is forced one grant.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request; held with f_addr stable until f_done
- f_addr  in  ADDR_W  fetch address
- f_done  out  1  one-cycle pulse, fetch access complete
- f_rdata  out  DATA_W  fetch read data, valid with f_done, held until next f_done
- f_err  out  1  valid with f_done; 1 = timeout
- m_req  in  1  memory-stage request; held with m_we/m_addr/m_wdata stable until m_done
- m_we  in  1  1 = write, 0 = read
- m_addr  in  ADDR_W  data address
- m_wdata  in  DATA_W  write data
- m_done  out  1  one-cycle pulse, data access complete
- m_rdata  out  DATA_W  read data, valid with m_done (reads only), held otherwise
- m_err  out  1  valid with m_done; 1 = timeout
- f_stall_req  out  1  combinational: f_req & ~f_done
- m_stall_req  out  1  combinational: m_req & ~m_done
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  one-cycle completion from memory; only meaningful while mem_req=1
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; timeout counter and starvation counter = 0.
  - All registered outputs = 0: mem_req, mem_we, mem_addr, mem_wdata, f_done, m_done, f_err, m_err, f_rdata, m_rdata.
  - Any in-flight access is dropped with no done pulse.
- States: IDLE, M_ACC, F_ACC, DONE.
- IDLE:
  - Grant selection at the edge:
    - Grant F if f_req and (~m_req or starve_cnt == STARVE_LIM).
    - Otherwise grant M if m_req.
  - On grant, latch the address (and for M, we/wdata) into the mem_* registers, set mem_req=1, and enter F_ACC or M_ACC.
  - An F grant forces mem_we=0 and mem_wdata=0.
  - Starvation counter:
    - Increments (saturating at STARVE_LIM) on each M grant taken while f_req=1.
    - Clears on any F grant.
    - Holds when nothing is granted.
- M_ACC / F_ACC:
  - mem_req holds at 1 and mem_* outputs are stable.
  - tmo_cnt increments each cycle. It is sized to hold TIMEOUT and is cleared on entry.
  - mem_ack=1 at an edge:
    - mem_req=0.
    - Latch mem_rdata into the granted client's rdata (M reads only; an M write leaves m_rdata unchanged).
    - Assert that client's done for one cycle with err=0; enter DONE.
  - No ack and tmo_cnt == TIMEOUT-1:
    - mem_req=0; assert that client's done with err=1.
    - rdata unchanged; enter DONE.
  - Ack on the same edge as the timeout: the ack wins, err=0.
- DONE:
  - Exactly one cycle; the done pulse is visible here. Next state is IDLE.
  - Requests are ignored, so a client sampling done can drop or replace its request before IDLE re-arbitrates.
  - mem_ack is ignored here and in IDLE; a late ack after a timeout has no effect.
- Latency: request seen at edge t → mem_req=1 from t+1. Ack sampled at edge t+k → done=1 during cycle t+k through t+k+1. Minimum latency request→done is 2 edges.
- Throughput: at most one access per 3 cycles when the ack is immediate.
- f_done and m_done are never 1 in the same cycle. mem_req is never 1 in DONE or IDLE.
- A request deasserted mid-access is illegal. The arbiter completes the access anyway and still pulses done.

Test Plan:
1. Reset: rst_n=0 mid-simulation, asynchronously → all registered outputs 0 before the next clk edge; f_stall_req follows f_req.
2. M write: m_req=1, m_we=1, m_addr=0x100, m_wdata=0xDEADBEEF, ack 3 cycles after mem_req rises → mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held during access; m_done one cycle, m_err=0; m_stall_req=1 until m_done.
3. Contention: f_req (f_addr=0x20) and m_req (read 0x40) rise together, ack returns mem_rdata=0x1111 then 0x2222 → M served first, m_rdata=0x1111; fetch served after DONE→IDLE, f_rdata=0x2222; f_stall_req high throughout.
4. Starvation: m_req re-asserted every IDLE with f_req held → 4 consecutive M grants, 5th grant goes to F; the counter clears and the next contention goes to M.
5. Timeout: F access, no ack → mem_req drops after 15 cycles in F_ACC; f_done=1 with f_err=1 and f_rdata unchanged; an ack one cycle later is ignored, with no spurious done.
6. Reset mid-access: rst_n low while in M_ACC → mem_req=0 immediately; no m_done ever; after release, a new f_req is granted normally.

Source files
------------

// File: rtl/y86_mem_arbiter.sv
// Two-client arbiter for the Y86 unified single-port memory.
// The fetch stage only reads. The memory stage reads or writes. Each access is
// sequenced IDLE -> {F_ACC|M_ACC} -> DONE. In IDLE the memory stage wins ties.
// After STARVE_LIM consecutive memory-stage wins while fetch waits, fetch is
// forced one grant. An access that sees no ack within TIMEOUT cycles is aborted
// and reported through the client's err flag.
module y86_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int TIMEOUT    = 15,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch client
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  // memory-stage client
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_done,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_err,
  // pipeline control
  output logic              f_stall_req,
  output logic              m_stall_req,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter widths: each counter must be able to hold its limit value.
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M_ACC = 2'd1,
    F_ACC = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tmo_cnt, tmo_cnt_n;
  logic [SW-1:0]     starve_cnt, starve_cnt_n;

  logic              mem_req_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              f_done_n, m_done_n, f_err_n, m_err_n;
  logic [DATA_W-1:0] f_rdata_n, m_rdata_n;

  logic              grant_f, grant_m, tmo_hit;

  // Fetch wins when data is idle, or when fetch has been passed over too often.
  assign grant_f = f_req & (~m_req | (starve_cnt == STARVE_MAX));
  assign grant_m = ~grant_f & m_req;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Stall requests hold the stage until its done pulse arrives.
  assign f_stall_req = f_req & ~f_done;
  assign m_stall_req = m_req & ~m_done;

  // State, counters and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f_done     <= 1'b0;
      m_done     <= 1'b0;
      f_err      <= 1'b0;
      m_err      <= 1'b0;
      f_rdata    <= '0;
      m_rdata    <= '0;
    end else begin
      state      <= state_n;
      tmo_cnt    <= tmo_cnt_n;
      starve_cnt <= starve_cnt_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      f_done     <= f_done_n;
      m_done     <= m_done_n;
      f_err      <= f_err_n;
      m_err      <= m_err_n;
      f_rdata    <= f_rdata_n;
      m_rdata    <= m_rdata_n;
    end
  end

  // Next-state and next-output logic; done pulses default low every cycle.
  always_comb begin
    state_n      = state;
    tmo_cnt_n    = tmo_cnt;
    starve_cnt_n = starve_cnt;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    f_done_n     = 1'b0;
    m_done_n     = 1'b0;
    f_err_n      = f_err;
    m_err_n      = m_err;
    f_rdata_n    = f_rdata;
    m_rdata_n    = m_rdata;

    unique case (state)
      IDLE: begin
        tmo_cnt_n = '0;
        if (grant_f) begin
          state_n      = F_ACC;
          mem_req_n    = 1'b1;
          mem_we_n     = 1'b0;
          mem_addr_n   = f_addr;
          mem_wdata_n  = '0;
          starve_cnt_n = '0;
        end else if (grant_m) begin
          state_n     = M_ACC;
          mem_req_n   = 1'b1;
          mem_we_n    = m_we;
          mem_addr_n  = m_addr;
          mem_wdata_n = m_wdata;
          // Only count wins that actually made fetch wait.
          if (f_req && (starve_cnt != STARVE_MAX))
            starve_cnt_n = starve_cnt + STARVE_ONE;
        end
      end

      F_ACC, M_ACC: begin
        // Ack beats timeout on the same edge.
        if (mem_ack || tmo_hit) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          if (state == F_ACC) begin
            f_done_n = 1'b1;
            f_err_n  = ~mem_ack;
            if (mem_ack)
              f_rdata_n = mem_rdata;
          end else begin
            m_done_n = 1'b1;
            m_err_n  = ~mem_ack;
            if (mem_ack && !mem_we)
              m_rdata_n = mem_rdata;
          end
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_ONE;
        end
      end

      // One dead cycle lets the client see done and retire its request.
      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
